// File: rtl/pkt_drain.sv
// Packet drain engine: on a rising edge of package_full, reads PKT_LEN bytes from the
// packet RAM and streams them out on a valid/ready byte port with sop/eop markers.
module pkt_drain #(
    parameter int PKT_LEN = 32,
    parameter int RAM_LAT = 1,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          package_full,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    ram_q,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          sop,
    output logic          eop,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic [2:0]    state_o
);

    // Output handshake: a byte transfers on a cycle where dout_valid and dout_ready are
    // both high; once dout_valid rises, dout/sop/eop hold until that transfer.

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(PKT_LEN - 1);
    localparam logic [1:0]    LAT_INIT = 2'(RAM_LAT);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lat_q, lat_d;
    logic [7:0]    dout_q, dout_d;
    logic          pf_q;
    logic          dout_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          overrun_q, overrun_d;
    logic          trig;

    assign trig = package_full & ~pf_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        dout_d    = dout_q;
        // A new packet edge is never queued; outside IDLE it only flags overrun.
        overrun_d = overrun_q | (trig & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_RD;
                    idx_d   = '0;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                lat_d   = LAT_INIT;
            end
            S_WAIT: begin
                if (lat_q == 2'd1) begin
                    dout_d  = ram_q;
                    state_d = S_PRESENT;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_PRESENT: begin
                if (dout_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            lat_q        <= '0;
            dout_q       <= '0;
            pf_q         <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            dout_q       <= dout_d;
            pf_q         <= package_full;
            dout_valid_q <= (state_d == S_PRESENT);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            overrun_q    <= overrun_d;
        end
    end

    // idx only changes when entering RD, so it doubles as the held read address.
    assign rd_en      = (state_q == S_RD);
    assign rd_addr    = idx_q;
    assign sop        = (state_q == S_PRESENT) && (idx_q == '0);
    assign eop        = (state_q == S_PRESENT) && (idx_q == LAST_IDX);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pkt_drain.sv
// Bench for pkt_drain: a 32-byte/latency-1 instance checked every cycle against an
// expected-byte queue, plus an 8-byte/latency-2 instance checked against literal timing.
module tb_pkt_drain;

    localparam int P1 = 32;
    localparam int P2 = 8;

    logic       clk;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // instance 1: PKT_LEN=32, RAM_LAT=1
    logic       package_full, rd_en, dout_valid, dout_ready, sop, eop, busy, done, overrun;
    logic [4:0] rd_addr;
    logic [7:0] ram_q = 8'h00;
    logic [7:0] dout;
    logic [2:0] state_dbg;

    // instance 2: PKT_LEN=8, RAM_LAT=2
    logic       pf2, rd_en2, dv2, sop2, eop2, busy2, done2, ovr2;
    logic [4:0] rd_addr2;
    logic [7:0] ram_q2 = 8'h00;
    logic [7:0] ram_s2 = 8'h00;
    logic [7:0] dout2;
    logic [2:0] state_dbg2;

    logic [7:0] mem [0:31];

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] got2_q [$];
    int         hs2_q [$];
    int         pos = 0;
    int         exp_addr = 0;
    int         rd_cnt = 0;
    int         hs_cnt = 0;
    int         done_cnt = 0;
    int         rd2_cnt = 0;
    int         first_valid_cyc = -1;
    int         t_trig = 0;
    logic       stalled = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    pkt_drain #(.PKT_LEN(P1), .RAM_LAT(1), .AW(5)) dut (
        .clk(clk), .rst(rst), .package_full(package_full),
        .rd_en(rd_en), .rd_addr(rd_addr), .ram_q(ram_q),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .sop(sop), .eop(eop), .busy(busy), .done(done), .overrun(overrun),
        .state_o(state_dbg)
    );

    pkt_drain #(.PKT_LEN(P2), .RAM_LAT(2), .AW(5)) dut2 (
        .clk(clk), .rst(rst), .package_full(pf2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .ram_q(ram_q2),
        .dout(dout2), .dout_valid(dv2), .dout_ready(1'b1),
        .sop(sop2), .eop(eop2), .busy(busy2), .done(done2), .overrun(ovr2),
        .state_o(state_dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: one-cycle and two-cycle read latency
    always @(posedge clk) if (rd_en) ram_q <= mem[rd_addr];
    always @(posedge clk) begin
        if (rd_en2) ram_s2 <= mem[rd_addr2];
        ram_q2 <= ram_s2;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_pkt(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic clear_stats();
        got_q.delete();
        rd_cnt = 0;
        hs_cnt = 0;
        first_valid_cyc = -1;
    endtask

    task automatic pulse_pf();
        @(posedge clk); #1 package_full = 1'b1;
        t_trig = cyc;
        @(posedge clk); #1 package_full = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int dc);
        int n;
        n  = 0;
        dc = -1;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for done", nm);
        end
    endtask

    task automatic wait_hs(input int n);
        int k;
        k = 0;
        while (hs_cnt < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_hs_bound", hs_cnt, n);
    endtask

    task automatic check_got(input string nm);
        check({nm, "_count"}, got_q.size(), P1);
        for (int i = 0; i < P1 && i < got_q.size(); i++) check({nm, "_byte"}, got_q[i], mem[i]);
        check({nm, "_rd_cnt"}, rd_cnt, P1);
        check({nm, "_exp_empty"}, exp_q.size(), 0);
    endtask

    // scoreboard compare for instance 1, every cycle
    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) begin
                check("rd_addr", rd_addr, exp_addr);
                exp_addr = (exp_addr == P1 - 1) ? 0 : exp_addr + 1;
                rd_cnt++;
            end
            if (dout_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled) check("dout_stable", dout, prev_dout);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    check("dout", dout, exp_q[0]);
                    check("sop", sop, pos == 0);
                    check("eop", eop, pos == P1 - 1);
                end
                prev_dout = dout;
                if (dout_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    got_q.push_back(dout);
                    pos = (pos == P1 - 1) ? 0 : pos + 1;
                    hs_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end else if (sop || eop) begin
                check("marker_without_valid", {sop, eop}, 0);
            end
            if (done) done_cnt++;
        end
    end

    // capture for instance 2
    always @(negedge clk) begin
        if (rst) begin
            if (rd_en2) rd2_cnt++;
            if (dv2) begin
                got2_q.push_back(dout2);
                hs2_q.push_back(cyc);
            end
        end
    end

    initial begin
        int dc;
        int k;
        int base_done;
        int base_rd;
        logic bp_stop;
        logic [7:0] pat;

        pat          = 8'b1001_0110;
        rst          = 1'b0;
        package_full = 1'b0;
        pf2          = 1'b0;
        dout_ready   = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);

        // reset state
        #23;
        check("rst_dout", dout, 0);
        check("rst_flags", {dout_valid, sop, eop, rd_en, busy, done, overrun}, 0);
        check("rst_rd_addr", rd_addr, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: plain drain, ready held high
        clear_stats();
        push_pkt(P1);
        pulse_pf();
        wait_done("t1_done", dc);
        check("t1_done_cycle", dc - t_trig, 97);
        check("t1_first_valid", first_valid_cyc - t_trig, 3);
        check("t1_busy_in_done", busy, 1);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        check("t1_first_byte", got_q[0], 8'hA0);
        check("t1_last_byte", got_q[P1-1], 8'hBF);
        check_got("t1");
        check("t1_overrun", overrun, 0);

        // 2: backpressure pattern
        clear_stats();
        push_pkt(P1);
        pulse_pf();
        bp_stop = 1'b0;
        k = 0;
        fork
            begin
                while (!bp_stop) begin
                    @(posedge clk); #1 dout_ready = pat[k % 8];
                    k++;
                end
            end
            begin
                wait_done("t2_done", dc);
                bp_stop = 1'b1;
            end
        join
        dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_got("t2");
        check("t2_slower", (dc - t_trig) > 97, 1);

        // 3: package_full held high across two drain lengths
        clear_stats();
        base_done = done_cnt;
        push_pkt(P1);
        @(posedge clk); #1 package_full = 1'b1;
        t_trig = cyc;
        wait_done("t3_done", dc);
        repeat (60) @(negedge clk);
        check("t3_one_drain", done_cnt - base_done, 1);
        check("t3_idle", busy, 0);
        check_got("t3");
        clear_stats();
        @(posedge clk); #1 package_full = 1'b0;
        push_pkt(P1);
        @(posedge clk); #1 package_full = 1'b1;
        wait_done("t3b_done", dc);
        @(posedge clk); #1 package_full = 1'b0;
        repeat (2) @(negedge clk);
        check_got("t3b");
        check("t3_overrun", overrun, 0);

        // 4: second edge at byte 10 -> overrun, dropped
        clear_stats();
        base_done = done_cnt;
        push_pkt(P1);
        pulse_pf();
        wait_hs(10);
        package_full = 1'b1;
        @(posedge clk); #1 package_full = 1'b0;
        @(posedge clk); #1;
        check("t4_overrun_set", overrun, 1);
        wait_done("t4_done", dc);
        repeat (60) @(negedge clk);
        check("t4_overrun_sticky", overrun, 1);
        check("t4_one_drain", done_cnt - base_done, 1);
        check("t4_idle", busy, 0);
        check_got("t4");

        // 5: async reset during PRESENT of byte 15
        clear_stats();
        push_pkt(P1);
        pulse_pf();
        wait_hs(15);
        k = 0;
        while (!dout_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_presenting", dout_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_dout", dout, 0);
        check("t5_rst_flags", {dout_valid, sop, eop, rd_en, busy, done, overrun}, 0);
        check("t5_rst_rd_addr", rd_addr, 0);
        exp_q.delete();
        pos = 0;
        exp_addr = 0;
        stalled = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        base_rd = rd_cnt;
        repeat (10) @(negedge clk);
        check("t5_idle_after_rst", busy, 0);
        check("t5_no_reads", rd_cnt - base_rd, 0);
        clear_stats();
        push_pkt(P1);
        pulse_pf();
        wait_done("t5_done", dc);
        repeat (2) @(negedge clk);
        check_got("t5");

        // 6: PKT_LEN=8, RAM_LAT=2 instance
        got2_q.delete();
        hs2_q.delete();
        rd2_cnt = 0;
        @(posedge clk); #1 pf2 = 1'b1;
        t_trig = cyc;
        @(posedge clk); #1 pf2 = 1'b0;
        dc = -1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (done2) begin
                dc = cyc;
                break;
            end
        end
        check("t6_done_cycle", dc - t_trig, 33);
        check("t6_count", got2_q.size(), P2);
        for (int i = 0; i < P2 && i < got2_q.size(); i++) begin
            check("t6_byte", got2_q[i], mem[i]);
            check("t6_hs_cycle", hs2_q[i] - t_trig, 4 + 4 * i);
        end
        check("t6_rd_cnt", rd2_cnt, P2);
        check("t6_overrun", ovr2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_drain.md
# pkt_drain

Packet drain engine for the 8x32 dual-port RAM packet buffer. When the write side signals that a packet is complete (`package_full` rising), the block walks the RAM read port from address 0 to PKT_LEN-1. It streams each byte out on a valid/ready byte interface with start/end-of-packet markers. It runs in the 100 MHz PLL clock domain, owns the RAM read port (`rd_en`/`rd_addr`), and drives a downstream consumer such as a UART/parallel transmitter.

## Interface
- PKT_LEN, 32: bytes per packet; addresses 0..PKT_LEN-1 are read; 2..32
- RAM_LAT, 1: RAM read latency in cycles from the `rd_en` cycle to valid `ram_q`; 1..3
- AW, 5: RAM address width
- clk  in  1  block clock, the 100 MHz PLL output
- rst  in  1  asynchronous reset, active low
- package_full  in  1  packet-complete level from the write side; the rising edge starts a drain
- rd_en  out  1  RAM read enable, one cycle per byte
- rd_addr  out  AW  RAM read address
- ram_q  in  8  RAM read data
- dout  out  8  output byte
- dout_valid  out  1  `dout` valid
- dout_ready  in  1  consumer accepts the byte when `dout_valid` and `dout_ready` are both high
- sop  out  1  high with `dout_valid` on byte 0
- eop  out  1  high with `dout_valid` on byte PKT_LEN-1
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after the last byte is accepted
- overrun  out  1  sticky; a new packet edge arrived while busy

## Operation
- Edge detect: register `package_full` into `pf_d`. Trigger = `package_full & ~pf_d`.
- States: IDLE, RD, WAIT, PRESENT, DONE.
- IDLE:
  - trigger -> RD with idx=0.
  - `busy`=0.
- RD:
  - `rd_en`=1, `rd_addr`=idx for exactly one cycle.
  - -> WAIT with latency counter = RAM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter is 1, `ram_q` is valid and is registered into `dout` at the closing edge.
  - -> PRESENT.
- PRESENT:
  - `dout_valid`=1.
  - `dout` holds stable until accepted.
  - `sop`=(idx==0), `eop`=(idx==PKT_LEN-1).
  - On handshake with idx<PKT_LEN-1: idx+1 -> RD.
  - On handshake with idx==PKT_LEN-1: -> DONE.
  - No handshake: stay.
- DONE:
  - `done`=1 for one cycle.
  - -> IDLE.
- `busy`=1 in RD, WAIT, PRESENT and DONE.
- Trigger while not IDLE: `overrun` set and stays set until reset. The current drain continues unaffected and the trigger is dropped (not queued).
- Trigger coinciding with the DONE cycle: counts as overrun and is dropped.
- Width rules:
  - idx is AW bits; `rd_addr`=idx.
  - idx never wraps: the terminal compare is against PKT_LEN-1, so PKT_LEN=32 uses the full address range with no overflow.
- `rd_en` is 0 in every state except RD. `rd_addr` holds its last value outside RD.
- All outputs are registered except `rd_addr`, `rd_en`, `sop` and `eop`, which decode directly from state/idx registers (no input-to-output combinational path).
- Reset:
  - Asynchronous assertion at any point, including mid-packet, forces IDLE immediately.
  - Reset values: `dout`=0, `dout_valid`=0, `sop`=0, `eop`=0, `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0, `overrun`=0, idx=0, `pf_d`=0.
  - A partially sent packet is abandoned and never resumed.
  - If `package_full` is already high when reset is released, that counts as a rising edge on the first clock (`pf_d`=0) and starts a drain.

## Timing
- Cycle T: clock edge samples the trigger. T+1: RD (`rd_en`=1, `rd_addr`=0).
- Byte n with RAM_LAT=L: RD at cycle R, WAIT for cycles R+1..R+L, PRESENT from R+L+1.
- With `dout_ready` held high:
  - each byte takes 2+L cycles;
  - a full packet takes PKT_LEN*(2+L) cycles from the first RD to the last handshake;
  - `done` follows in the next cycle.
- L=1, PKT_LEN=32, ready=1:
  - first `dout_valid` at T+3;
  - last handshake at T+96;
  - `done` at T+97;
  - `busy` falls at T+98;
  - earliest new trigger accepted when sampled at T+98.
- Backpressure: each cycle with `dout_ready`=0 in PRESENT adds exactly one cycle. `dout`/`sop`/`eop` must stay stable throughout.

## Test plan
- Reset release, RAM preloaded with addr i = 8'hA0+i, pulse `package_full` with ready=1: 32 bytes A0..BF in order, `sop` on A0 only, `eop` on BF only, `done` pulse at T+97, `rd_addr` sequence 0..31.
- Same packet with `dout_ready` toggling 1-0-0-1 pseudo-randomly: identical byte order, `dout` stable while stalled, no byte duplicated or lost, one `rd_en` per byte.
- Second `package_full` rising edge at byte 10 of a drain: `overrun`=1 (sticky), current packet completes all 32 bytes, no second drain starts.
- `package_full` held high continuously across two drains: exactly one drain. A low-then-high transition after IDLE starts the next drain.
- `rst` asserted while PRESENT on byte 15: all outputs 0 asynchronously. After release with `package_full` low, block idles. A new edge restarts from `rd_addr`=0.
- RAM_LAT=2, PKT_LEN=8 build, ready=1: bytes 0..7 correct, 4 cycles per byte, `done` at T+33.
